// File: rtl/beep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beep_pkg
//  Description : Shared definitions for the buzzer scheduler: channel count,
//                channel indices, pattern-timer state encoding and a one-hot
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package beep_pkg;

  localparam int NCH = 3;

  // Channel indices in priority order (lowest index wins)
  localparam logic [1:0] CH_ALARM = 2'd0;
  localparam logic [1:0] CH_ERR   = 2'd1;
  localparam logic [1:0] CH_CLICK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } beep_state_e;

  // One-hot vector with the bit of channel ch set
  function automatic logic [NCH-1:0] ch_onehot(input logic [1:0] ch);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 2'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beep_pattern_timer.sv
`default_nettype none
// ============================================================================
//  Module      : beep_pattern_timer
//  Description : Plays one beep pattern: `reps` repetitions of on_cyc high
//                cycles followed by off_cyc gap cycles. Pulses finish in the
//                last cycle of a normally completed pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module beep_pattern_timer
  import beep_pkg::*;
#(
  parameter int CNT_W = 28,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] on_cyc,
  input  logic [CNT_W-1:0] off_cyc,
  input  logic [REP_W-1:0] reps,
  output logic             beep,
  output logic             busy,
  output logic             finish
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  beep_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             beep_q, beep_d;
  logic             busy_q, busy_d;
  logic             rep_end;

  // Next-state logic: phase counting, repetition bookkeeping, abort handling
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    rep_end = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_ON;
          cnt_d   = '0;
          rep_d   = reps - REP_ONE;
        end
      end
      ST_ON: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rep_d   = '0;
        end else if (cnt_q == on_cyc - CNT_ONE) begin
          cnt_d = '0;
          if (off_cyc != '0) state_d = ST_OFF;
          else               rep_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_OFF: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rep_d   = '0;
        end else if (cnt_q == off_cyc - CNT_ONE) begin
          cnt_d   = '0;
          rep_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rep_d   = '0;
      end
    endcase

    // End of one repetition (after its gap, or after ON when there is no gap)
    if (rep_end) begin
      if (rep_q != '0) begin
        rep_d   = rep_q - REP_ONE;
        state_d = ST_ON;
      end else begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    beep_d = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      beep_q  <= beep_d;
      busy_q  <= busy_d;
    end
  end

  assign beep = beep_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/beep_sched.sv
`default_nettype none
// ============================================================================
//  Module      : beep_sched
//  Description : Shares one active buzzer between three requesters with
//                per-channel pending latches, fixed-priority non-preemptive
//                grant and per-channel beep patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module beep_sched
  import beep_pkg::*;
#(
  parameter int          CNT_W = 28,
  parameter int unsigned ON0   = 25_000_000,
  parameter int unsigned OFF0  = 125_000_000,
  parameter int unsigned REP0  = 3,
  parameter int unsigned ON1   = 50_000_000,
  parameter int unsigned OFF1  = 25_000_000,
  parameter int unsigned REP1  = 2,
  parameter int unsigned ON2   = 2_500_000,
  parameter int unsigned OFF2  = 0,
  parameter int unsigned REP2  = 1,
  parameter int          REP_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       stop,
  output logic       beep,
  output logic       busy,
  output logic [1:0] active_ch,
  output logic [2:0] done
);

  logic [NCH-1:0]   pending_q, pending_d;
  logic [1:0]       active_ch_q, active_ch_d;
  logic [NCH-1:0]   done_q, done_d;

  logic             grant_vld;
  logic [1:0]       grant_ch;
  logic [1:0]       sel_ch;
  logic [CNT_W-1:0] on_cyc, off_cyc;
  logic [REP_W-1:0] reps;
  logic             tmr_busy, tmr_finish;

  // Lowest-index pending channel wins; only granted while the timer is idle
  always_comb begin
    grant_ch = CH_ALARM;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_ch = 2'(i);
    end
    grant_vld = !tmr_busy && (pending_q != '0) && !stop;
  end

  // Pattern parameters of the channel being started or currently running
  always_comb begin
    sel_ch  = grant_vld ? grant_ch : active_ch_q;
    on_cyc  = CNT_W'(ON0);
    off_cyc = CNT_W'(OFF0);
    reps    = REP_W'(REP0);
    case (sel_ch)
      CH_ERR: begin
        on_cyc  = CNT_W'(ON1);
        off_cyc = CNT_W'(OFF1);
        reps    = REP_W'(REP1);
      end
      CH_CLICK: begin
        on_cyc  = CNT_W'(ON2);
        off_cyc = CNT_W'(OFF2);
        reps    = REP_W'(REP2);
      end
      default: ;
    endcase
  end

  // Pending latches (a same-cycle request beats the grant clear, stop beats all),
  // granted channel and completion pulse
  always_comb begin
    pending_d   = pending_q;
    active_ch_d = active_ch_q;
    done_d      = '0;
    if (stop) begin
      pending_d = '0;
    end else begin
      if (grant_vld) begin
        pending_d   = pending_q & ~ch_onehot(grant_ch);
        active_ch_d = grant_ch;
      end
      pending_d = pending_d | req;
      if (tmr_finish) done_d = ch_onehot(active_ch_q);
    end
  end

  // Scheduler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      active_ch_q <= CH_ALARM;
      done_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      active_ch_q <= active_ch_d;
      done_q      <= done_d;
    end
  end

  beep_pattern_timer #(
    .CNT_W (CNT_W),
    .REP_W (REP_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (grant_vld),
    .abort   (stop),
    .on_cyc  (on_cyc),
    .off_cyc (off_cyc),
    .reps    (reps),
    .beep    (beep),
    .busy    (tmr_busy),
    .finish  (tmr_finish)
  );

  assign busy      = tmr_busy;
  assign active_ch = active_ch_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_beep_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beep_sched
//  Description : Self-checking bench for beep_sched: directed scenario tables
//                plus randomized traffic against a pattern-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beep_sched;

  localparam int CNT_W = 8;
  localparam int REP_W = 4;
  localparam int ON0 = 4, OFF0 = 3, REP0 = 2;
  localparam int ON1 = 6, OFF1 = 2, REP1 = 1;
  localparam int ON2 = 2, OFF2 = 0, REP2 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       stop = 1'b0;
  logic       beep, busy;
  logic [1:0] active_ch;
  logic [2:0] done;

  always #5 clk = ~clk;

  beep_sched #(
    .CNT_W (CNT_W), .REP_W (REP_W),
    .ON0 (ON0), .OFF0 (OFF0), .REP0 (REP0),
    .ON1 (ON1), .OFF1 (OFF1), .REP1 (REP1),
    .ON2 (ON2), .OFF2 (OFF2), .REP2 (REP2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .stop      (stop),
    .beep      (beep),
    .busy      (busy),
    .active_ch (active_ch),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: each grant expands into a per-cycle beep plan
  logic       m_busy = 1'b0, m_beep = 1'b0;
  logic [1:0] m_act  = 2'd0;
  logic [2:0] m_done = 3'b000, m_pend = 3'b000;
  bit         m_plan[$];

  function automatic int on_of(input int ch);
    return (ch == 0) ? ON0 : (ch == 1) ? ON1 : ON2;
  endfunction
  function automatic int off_of(input int ch);
    return (ch == 0) ? OFF0 : (ch == 1) ? OFF1 : OFF2;
  endfunction
  function automatic int rep_of(input int ch);
    return (ch == 0) ? REP0 : (ch == 1) ? REP1 : REP2;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] rq, input logic s);
    int g;
    if (r) begin
      m_plan.delete();
      m_busy = 0; m_beep = 0; m_act = 0; m_done = 0; m_pend = 0;
    end else if (s) begin
      m_plan.delete();
      m_busy = 0; m_beep = 0; m_done = 0; m_pend = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (m_pend != 0) begin
          g = m_pend[0] ? 0 : m_pend[1] ? 1 : 2;
          for (int r2 = 0; r2 < rep_of(g); r2++) begin
            for (int k = 0; k < on_of(g); k++)  m_plan.push_back(1'b1);
            for (int k = 0; k < off_of(g); k++) m_plan.push_back(1'b0);
          end
          m_act     = 2'(g);
          m_pend[g] = 1'b0;
          m_busy    = 1'b1;
          m_beep    = m_plan.pop_front();
        end
      end else if (m_plan.size() == 0) begin
        m_done = 3'b001 << m_act;
        m_busy = 0;
        m_beep = 0;
      end else begin
        m_beep = m_plan.pop_front();
      end
      m_pend = m_pend | rq;
    end
  endtask

  // One clock: advance the model with this cycle's inputs, then compare
  task automatic cycle();
    model_step(rst, req, stop);
    @(posedge clk);
    #1;
    cyc++;
    check("model_beep", beep, m_beep);
    check("model_busy", busy, m_busy);
    check("model_done", done, m_done);
    check("model_active_ch", active_ch, m_act);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000; stop = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios: stimulus per relative cycle, observed outputs
  logic [2:0] st_req  [64];
  logic       st_stop [64];
  logic       ob_beep [65];
  logic       ob_busy [65];
  logic [2:0] ob_done [65];
  logic [1:0] ob_act  [65];

  typedef struct {
    int         lo;
    int         hi;
    logic       beep;
    logic       busy;
    logic [2:0] done;
    logic [1:0] act;
  } exp_t;
  exp_t tbl[$];

  task automatic clear_stim();
    for (int t = 0; t < 64; t++) begin
      st_req[t]  = 3'b000;
      st_stop[t] = 1'b0;
    end
    tbl.delete();
  endtask

  task automatic add(input int lo, input int hi, input logic b, input logic bs,
                     input logic [2:0] d, input logic [1:0] a);
    exp_t e;
    e.lo = lo; e.hi = hi; e.beep = b; e.busy = bs; e.done = d; e.act = a;
    tbl.push_back(e);
  endtask

  task automatic run_scn(input int n);
    ob_beep[0] = beep; ob_busy[0] = busy; ob_done[0] = done; ob_act[0] = active_ch;
    for (int t = 0; t < n; t++) begin
      req  = st_req[t];
      stop = st_stop[t];
      cycle();
      ob_beep[t+1] = beep; ob_busy[t+1] = busy; ob_done[t+1] = done; ob_act[t+1] = active_ch;
    end
    req = 3'b000; stop = 1'b0;
  endtask

  task automatic check_tbl(input string scn);
    foreach (tbl[k]) begin
      for (int t = tbl[k].lo; t <= tbl[k].hi; t++) begin
        check({scn, "_beep"}, ob_beep[t], tbl[k].beep);
        check({scn, "_busy"}, ob_busy[t], tbl[k].busy);
        check({scn, "_done"}, ob_done[t], tbl[k].done);
        check({scn, "_active_ch"}, ob_act[t], tbl[k].act);
      end
    end
  endtask

  initial begin
    int ndone;
    logic eb;

    // Reset held with all requests asserted: outputs stay quiet, nothing latched
    rst = 1'b1; req = 3'b111; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_beep", beep, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 3'b000);
      check("rst_active_ch", active_ch, 2'd0);
    end
    rst = 1'b0; req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("post_rst_beep", beep, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end

    // Single ch0 pulse at cycle 10
    do_reset();
    clear_stim();
    st_req[10] = 3'b001;
    add(0, 11, 0, 0, 3'b000, 0);
    add(12, 15, 1, 1, 3'b000, 0);
    add(16, 18, 0, 1, 3'b000, 0);
    add(19, 22, 1, 1, 3'b000, 0);
    add(23, 25, 0, 1, 3'b000, 0);
    add(26, 26, 0, 0, 3'b001, 0);
    add(27, 30, 0, 0, 3'b000, 0);
    run_scn(30);
    check_tbl("ch0_single");

    // Simultaneous ch1+ch2 at cycle 5: ch1 first, then ch2
    do_reset();
    clear_stim();
    st_req[5] = 3'b110;
    add(0, 6, 0, 0, 3'b000, 0);
    add(7, 12, 1, 1, 3'b000, 1);
    add(13, 14, 0, 1, 3'b000, 1);
    add(15, 15, 0, 0, 3'b010, 1);
    add(16, 17, 1, 1, 3'b000, 2);
    add(18, 18, 0, 0, 3'b100, 2);
    add(19, 24, 0, 0, 3'b000, 2);
    run_scn(24);
    check_tbl("prio");

    // ch0 requested while ch2 plays: no preemption
    do_reset();
    clear_stim();
    st_req[2] = 3'b100;
    st_req[4] = 3'b001;
    add(0, 3, 0, 0, 3'b000, 0);
    add(4, 5, 1, 1, 3'b000, 2);
    add(6, 6, 0, 0, 3'b100, 2);
    add(7, 10, 1, 1, 3'b000, 0);
    add(11, 13, 0, 1, 3'b000, 0);
    add(14, 17, 1, 1, 3'b000, 0);
    add(18, 20, 0, 1, 3'b000, 0);
    add(21, 21, 0, 0, 3'b001, 0);
    add(22, 26, 0, 0, 3'b000, 0);
    run_scn(26);
    check_tbl("nopreempt");

    // stop during the second ch0 ON phase with ch1 pending
    do_reset();
    clear_stim();
    st_req[0]  = 3'b001;
    st_req[3]  = 3'b010;
    st_stop[10] = 1'b1;
    add(0, 1, 0, 0, 3'b000, 0);
    add(2, 5, 1, 1, 3'b000, 0);
    add(6, 8, 0, 1, 3'b000, 0);
    add(9, 10, 1, 1, 3'b000, 0);
    add(11, 30, 0, 0, 3'b000, 0);
    run_scn(30);
    check_tbl("stop");

    // req[2] held for 30 cycles: back-to-back click patterns
    do_reset();
    clear_stim();
    for (int t = 0; t < 30; t++) st_req[t] = 3'b100;
    run_scn(42);
    ndone = 0;
    for (int t = 0; t <= 42; t++) begin
      eb = (t >= 2 && t <= 33 && ((t - 2) % 3) != 2);
      check("held_beep", ob_beep[t], eb);
      if (ob_done[t] == 3'b100) ndone++;
    end
    check("held_done_count", ndone, 11);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      stop = ($urandom_range(0, 79) == 0);
      for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 24) == 0);
      cycle();
    end
    rst = 1'b0; stop = 1'b0; req = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
